serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial, LSB-first a - b with borrow and signed overflow
//               flags, wrapped in a valid/ready start and result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int                 CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   c_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_recover;

    logic w_ai;
    logic w_bi;
    logic w_d;
    logic w_bout;

    // Operands rotate right once per bit, so after WIDTH bits they are back
    // in their latched order and the sign bits are available for overflow.
    assign w_ai   = r_a[0];
    assign w_bi   = r_b[0];
    assign w_d    = w_ai ^ w_bi ^ r_borrow;
    assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
            r_recover <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The first IDLE cycle after a result handshake never accepts.
                    r_recover <= 1'b0;
                    if (start_valid && !r_recover) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_a      <= {r_a[0], r_a[WIDTH-1:1]};
                    r_b      <= {r_b[0], r_b[WIDTH-1:1]};
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_BIT) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_state   <= IDLE;
                        r_recover <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign start_ready  = (r_state == IDLE);
    assign result_valid = (r_state == DONE);
    assign diff         = r_diff;
    assign borrow_out   = r_borrow;
    assign overflow     = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_diff[WIDTH-1] ^ r_a[WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed and random checks of serial_subtractor (WIDTH = 8)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .diff         (diff),
        .borrow_out   (borrow_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, borrow, diff[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv);
        int ud;
        int sd;
        logic [7:0] d;
        logic bo;
        logic ov;
        ud = int'(av) - int'(bv);
        sd = int'($signed(av)) - int'($signed(bv));
        d  = ud[7:0];
        bo = (int'(av) < int'(bv));
        ov = (sd > 127) || (sd < -128);
        return {ov, bo, d};
    endfunction

    // One complete operation: offer, wait for accept, check latency and
    // results, optionally stall the result, then complete the handshake.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
        logic [9:0] e;
        logic       acc;
        e   = model(av, bv);
        acc = 1'b0;
        start_valid  = 1'b1;
        a            = av;
        b            = bv;
        result_ready = (hold == 0);
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
            if (!start_ready) acc = 1'b1;
        end
        chk("accept", {31'd0, acc}, 32'd1);
        start_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 1; i < WIDTH; i++) tick();
        chk("valid_early", {31'd0, result_valid}, 32'd0);
        tick();
        chk("valid_latency", {31'd0, result_valid}, 32'd1);
        chk("diff", {24'd0, diff}, {24'd0, e[7:0]});
        chk("borrow", {31'd0, borrow_out}, {31'd0, e[8]});
        chk("overflow", {31'd0, overflow}, {31'd0, e[9]});
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
            chk("hold_sready", {31'd0, start_ready}, 32'd0);
            chk("hold_diff", {24'd0, diff}, {24'd0, e[7:0]});
            chk("hold_flags", {30'd0, overflow, borrow_out}, {30'd0, e[9:8]});
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        tick();
        chk("hs_valid", {31'd0, result_valid}, 32'd0);
        chk("hs_sready", {31'd0, start_ready}, 32'd1);
        result_ready = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] pa;
        logic [7:0] pb;
        logic       prev_sr;
        int         last_acc;
        int         n_acc;

        rst          = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = '0;
        b            = '0;
        tick();
        tick();
        chk("rst_sready", {31'd0, start_ready}, 32'd1);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_outs", {21'd0, overflow, borrow_out, diff}, 32'd0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 0);
        run_op(8'h03, 8'h05, 0);
        run_op(8'h80, 8'h01, 0);
        run_op(8'h7F, 8'hFF, 0);
        run_op(8'hA5, 8'hA5, 0);
        run_op(8'h3C, 8'hC3, 5);

        // Reset abort while BUSY, sampled on the 4th BUSY cycle's edge.
        start_valid = 1'b1;
        a = 8'hEE;
        b = 8'h11;
        tick();
        tick();
        chk("abort_accept", {31'd0, start_ready}, 32'd0);
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        start_valid = 1'b1;
        tick();
        rst = 1'b0;
        start_valid = 1'b0;
        chk("abort_sready", {31'd0, start_ready}, 32'd1);
        chk("abort_valid", {31'd0, result_valid}, 32'd0);
        chk("abort_outs", {21'd0, overflow, borrow_out, diff}, 32'd0);
        run_op(8'h10, 8'h01, 0);

        for (int k = 0; k < 20; k++) begin
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        // Back-to-back with start_valid and result_ready held high.
        start_valid  = 1'b1;
        result_ready = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
        prev_sr  = start_ready;
        last_acc = -1;
        n_acc    = 0;
        for (int cyc = 1; cyc <= 80 && n_acc < 4; cyc++) begin
            pa = a;
            pb = b;
            tick();
            if (result_valid) begin
                if (qa.size() == 0) begin
                    chk("b2b_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = model(qa.pop_front(), qb.pop_front());
                    chk("b2b_result", {22'd0, overflow, borrow_out, diff}, {22'd0, e});
                end
            end
            if (prev_sr && !start_ready) begin
                qa.push_back(pa);
                qb.push_back(pb);
                if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd11);
                last_acc = cyc;
                n_acc++;
                a = 8'($urandom);
                b = 8'($urandom);
            end
            prev_sr = start_ready;
        end
        chk("b2b_accepts", 32'(n_acc), 32'd4);
        start_valid = 1'b0;
        for (int i = 0; i < 12 && qa.size() > 0; i++) begin
            tick();
            if (result_valid) begin
                e = model(qa.pop_front(), qb.pop_front());
                chk("b2b_drain", {22'd0, overflow, borrow_out, diff}, {22'd0, e});
            end
        end
        chk("b2b_drained", 32'(qa.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
